// File: rtl/risc_mc_controller.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing with a sticky illegal-instruction trap.
// Optional performance counters are enabled by defining RISC_MC_CTRL_PERF_CNT_EN.
`timescale 1ns/1ps
module risc_mc_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  Op_Code,
    input  logic [9:0]  funct,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        alu_ltu,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        ir_we,
    output logic        reg_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic        trap,
    output logic [2:0]  state,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    state_t cur;
    state_t nxt;
    logic   legal;
    logic   br_taken;
    logic   funct_unused;

    // Upper funct bits are consumed by the ALU decoder, not by this FSM.
    assign funct_unused = ^funct[9:3];
    assign state        = cur;

    assign legal = Op_Code inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                   OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};

    always_comb begin
        case (funct[2:0])
            3'b000:  br_taken = alu_zero;
            3'b001:  br_taken = !alu_zero;
            3'b100:  br_taken = alu_lt;
            3'b101:  br_taken = !alu_lt;
            3'b110:  br_taken = alu_ltu;
            3'b111:  br_taken = !alu_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) cur <= S_FETCH;
        else     cur <= nxt;
    end

    always_comb begin
        nxt       = cur;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        reg_we    = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'b00;
        alu_src_b = 1'b0;
        alu_op    = 2'b00;
        wb_sel    = 2'b00;
        trap      = 1'b0;
        // Outputs stay at their zero defaults while rst is high so reset wins over any handshake.
        if (!rst) begin
            case (cur)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_we = 1'b1;
                        nxt   = S_DECODE;
                    end
                end
                S_DECODE: nxt = legal ? S_EXEC : S_TRAP;
                S_EXEC: begin
                    case (Op_Code)
                        OP_R: begin
                            alu_op = 2'b10;
                            nxt    = S_WB;
                        end
                        OP_I: begin
                            alu_src_b = 1'b1;
                            alu_op    = 2'b10;
                            nxt       = S_WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_src_b = 1'b1;
                            nxt       = S_MEM;
                        end
                        OP_JALR: begin
                            alu_src_b = 1'b1;
                            nxt       = S_WB;
                        end
                        OP_BRANCH: begin
                            alu_op = 2'b01;
                            if (funct[2:1] == 2'b01) begin
                                nxt = S_TRAP;
                            end else begin
                                pc_we  = 1'b1;
                                pc_sel = br_taken ? 2'b01 : 2'b00;
                                nxt    = S_FETCH;
                            end
                        end
                        default: nxt = S_WB;
                    endcase
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (Op_Code == OP_STORE);
                    if (dmem_ready) begin
                        if (Op_Code == OP_STORE) begin
                            pc_we = 1'b1;
                            nxt   = S_FETCH;
                        end else begin
                            nxt = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_we = 1'b1;
                    pc_we  = 1'b1;
                    nxt    = S_FETCH;
                    case (Op_Code)
                        OP_LOAD: wb_sel = 2'b01;
                        OP_JAL: begin
                            wb_sel = 2'b10;
                            pc_sel = 2'b01;
                        end
                        OP_JALR: begin
                            wb_sel    = 2'b10;
                            pc_sel    = 2'b10;
                            alu_src_b = 1'b1;
                        end
                        OP_LUI:  wb_sel = 2'b11;
                        default: wb_sel = 2'b00;
                    endcase
                end
                S_TRAP: trap = 1'b1;
                default: nxt = S_TRAP;
            endcase
        end
    end

`ifdef RISC_MC_CTRL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (pc_we) instret_cnt <= instret_cnt + 32'd1;
        end
    end
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: doc/risc_mc_controller.md
RISC_MC_CONTROLLER -- requirements
Module: risc_mc_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have these ports, one per line:
- Op_Code  in  7  opcode field from the instruction decoder
- funct  in  10  {funct7, funct3} from the instruction decoder
- alu_zero  in  1  ALU result == 0
- alu_lt  in  1  signed rs1 < rs2
- alu_ltu  in  1  unsigned rs1 < rs2
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- dmem_ready  in  1  data access complete
- ir_we  out  1  instruction register load strobe
- reg_we  out  1  register-file write strobe
- pc_we  out  1  PC update strobe
- pc_sel  out  2  00 PC+4, 01 PC+Imm, 10 {ALU[31:1],0}
- alu_src_b  out  1  0 rs2, 1 Imm
- alu_op  out  2  00 add, 01 subtract/compare, 10 funct-driven
- wb_sel  out  2  00 ALU, 01 memory, 10 PC+4, 11 Imm
- trap  out  1  illegal instruction, sticky
- state  out  3  current FSM state
- cycle_cnt  out  32  cycle counter (REQ-020)
- instret_cnt  out  32  retired-instruction counter (REQ-020)

Function
REQ-003 SHALL implement FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7; all other encodings SHALL transition to TRAP.
REQ-004 FETCH: SHALL hold imem_req=1 until imem_ready=1; in the ready cycle SHALL pulse ir_we for one cycle and go to DECODE.
REQ-005 DECODE: SHALL last exactly one cycle; SHALL go to EXEC for legal opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111 and to TRAP for all others.
REQ-006 EXEC, R-type (0110011): alu_src_b=0, alu_op=10. I-type ALU (0010011): alu_src_b=1, alu_op=10. Load/store: alu_src_b=1, alu_op=00. Next state MEM for load/store, WB for all others except branch.
REQ-007 EXEC, branch (1100011): alu_src_b=0, alu_op=01; condition from funct[2:0]: 000 alu_zero, 001 !alu_zero, 100 alu_lt, 101 !alu_lt, 110 alu_ltu, 111 !alu_ltu. SHALL pulse pc_we with pc_sel=01 if taken, else 00, then go to FETCH; funct[2:0]=010/011 SHALL go to TRAP with no pc_we.
REQ-008 MEM: SHALL hold dmem_req=1, dmem_we=1 for stores only, until dmem_ready=1. Store: pc_we pulse with pc_sel=00 in the ready cycle, then FETCH. Load: go to WB.
REQ-009 WB: SHALL pulse reg_we and pc_we for one cycle, then go to FETCH. wb_sel: load 01; JAL/JALR 10; LUI 11; others 00. pc_sel: JAL 01, JALR 10 (alu_src_b=1, alu_op=00 held), others 00.
REQ-010 Latency with zero-wait memory: ALU/LUI/AUIPC/JAL/JALR 4 cycles, load 5, store 4, branch 3.
REQ-011 Strobes ir_we, reg_we and pc_we SHALL each be high for at most one cycle per instruction; they SHALL never be high in TRAP.
REQ-012 imem_ready outside FETCH and dmem_ready outside MEM SHALL be ignored.
REQ-013 TRAP: trap=1, all requests and strobes 0; SHALL remain in TRAP until rst.
REQ-014 Outputs not specified for a state SHALL be 0.

Reset
REQ-015 rst=1 at a rising edge SHALL force state=FETCH, trap=0 and every strobe/request to 0 in the following cycle, including mid-handshake in FETCH or MEM.
REQ-016 After reset, imem_req SHALL assert in the first cycle after rst deasserts.
REQ-017 Reset values of all other outputs SHALL be 0; both counters SHALL reset to 0.
REQ-018 rst SHALL take priority over every other input.

Configuration
REQ-019 Macro RISC_MC_CTRL_PERF_CNT_EN SHALL select performance counters.
REQ-020 Macro defined: cycle_cnt SHALL increment every non-reset cycle; instret_cnt SHALL increment on each pc_we pulse. Both are 32-bit and wrap 0xFFFFFFFF->0. In TRAP, cycle_cnt keeps counting and instret_cnt holds.
REQ-021 Macro undefined: cycle_cnt and instret_cnt SHALL be constant 0 with no counter flops.

Verification
REQ-022 ADD (0110011, funct=0), imem_ready/dmem_ready tied 1 -> states 0,1,2,4; reg_we and pc_we high in cycle 4, wb_sel=00, pc_sel=00.
REQ-023 LW with dmem_ready low 3 cycles -> dmem_req high 4 cycles, dmem_we=0; WB follows with wb_sel=01; total 8 cycles.
REQ-024 BNE with alu_zero=0 -> pc_we with pc_sel=01 in EXEC, no reg_we, 3 cycles. BNE with alu_zero=1 -> pc_sel=00.
REQ-025 Op_Code=0000000 -> trap=1 from the cycle after DECODE, imem_req stays 0 for 20 cycles; rst then returns state=FETCH with trap=0.
REQ-026 rst asserted during MEM wait of SW -> next cycle state=0, dmem_req=0, no pc_we. With RISC_MC_CTRL_PERF_CNT_EN defined, 10 ADDs -> instret_cnt=10, cycle_cnt=40.
